multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings fixed below.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 op  input  7  opcode from the instruction register; stable from DECODE until the instruction's return to FETCH.
REQ-005 zero  input  1  ALU zero flag, sampled in BEQ.
REQ-006 mem_ready  input  1  memory handshake; an access completes on the clk edge where mem_ready=1.
REQ-007 pc_write  output  1  PC load enable, equal to pc_update OR (branch AND zero).
REQ-008 adr_src  output  1  memory address select: 0=PC, 1=ALU-out register.
REQ-009 mem_write  output  1  data memory write strobe.
REQ-010 ir_write  output  1  instruction register load enable.
REQ-011 reg_write  output  1  register-file write enable.
REQ-012 result_src  output  2  result select: 00=ALU-out register, 01=read data, 10=ALU result.
REQ-013 alu_src_a  output  2  ALU A select: 00=PC, 01=old PC, 10=rs1 data.
REQ-014 alu_src_b  output  2  ALU B select: 00=rs2 data, 01=immediate, 10=constant 4.
REQ-015 alu_op  output  2  ALU decoder class: 00=add, 01=sub, 10=funct-decoded.
REQ-016 illegal_op  output  1  one-cycle pulse while in DECODE with an unsupported op.
REQ-017 state  output  4  current state encoding, for debug.

Function
REQ-018 State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10; codes 11-15 go to FETCH on the next edge.
REQ-019 Outputs are Moore (decoded from state only) except ir_write, pc_update and mem_write, which are additionally gated by mem_ready where stated; any output not listed for a state is 0.
REQ-020 FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10, ir_write=pc_update=mem_ready; hold FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-021 DECODE: a=01, b=01, alu_op=00 (branch target precompute); next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECR
- 0010011 -> EXECI
- 1100011 -> BEQ
- 1101111 -> JAL (see REQ-033)
- any other op -> FETCH, with illegal_op=1.
REQ-022 MEMADR: a=10, b=01, alu_op=00; op 0000011 -> MEMREAD, else -> MEMWRITE.
REQ-023 MEMREAD: adr_src=1, result_src=00; hold while mem_ready=0; -> MEMWB on mem_ready=1.
REQ-024 MEMWB: result_src=01, reg_write=1; -> FETCH.
REQ-025 MEMWRITE: adr_src=1, result_src=00, mem_write=mem_ready; hold while mem_ready=0; -> FETCH on mem_ready=1; exactly one mem_write cycle per store.
REQ-026 EXECR: a=10, b=00, alu_op=10; -> ALUWB.
REQ-027 EXECI: a=10, b=01, alu_op=10; -> ALUWB.
REQ-028 ALUWB: result_src=00, reg_write=1; -> FETCH.
REQ-029 BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1; pc_write=zero; -> FETCH.
REQ-030 Latency in cycles, with mem_ready tied high:
- lw 5
- sw 4
- R-type / I-type 4
- beq 3
- jal 4
Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.

Reset
REQ-031 rst=1 at a clk edge forces state=FETCH regardless of current state, including mid-access or stall; all outputs then take FETCH values (ir_write/pc_update follow mem_ready).
REQ-032 While rst=1, reg_write=0 and mem_write=0; no store or register write occurs on any edge where rst is asserted.

Configuration
REQ-033 Macro JAL_EN: when defined, op 1101111 -> JAL state (a=01, b=10, alu_op=00, result_src=00, pc_update=1; -> ALUWB); when undefined, JAL is never entered, op 1101111 is illegal (-> FETCH, illegal_op=1), and state code 9 is treated like codes 11-15.

Verification
REQ-034 lw (op=0000011), mem_ready=1 -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4; result_src=01 in state 4.
REQ-035 sw (op=0100011), mem_ready low for 2 cycles in MEMWRITE -> state 5 held 3 cycles; mem_write=1 exactly once, on the third cycle.
REQ-036 beq (op=1100011): zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both cases return to FETCH after 3 cycles.
REQ-037 op=1111111 -> illegal_op=1 for one cycle in DECODE, next state 0, and no reg_write or mem_write pulse.
REQ-038 rst=1 asserted while in MEMREAD with mem_ready=0 -> state=0 on the next edge, mem_write=0, reg_write=0.
REQ-039 op=1101111: with JAL_EN -> sequence 0,1,9,7,0 with pc_write=1 in state 9; without JAL_EN -> 0,1,0 with illegal_op=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM for a multicycle RISC-V style datapath. The FSM walks each
//   instruction through FETCH / DECODE / execute / write-back states and drives
//   the datapath mux selects and write enables for the current state.
//
//   Control outputs are Moore (a function of the state only) and are held in a
//   register alongside the state. The only exceptions are the strobes that must
//   follow the memory handshake (ir_write, the PC update in FETCH, mem_write),
//   the branch PC write (zero flag) and illegal_op (opcode in DECODE).
//
// Configuration macro:
//   JAL_EN  when defined, opcode 1101111 runs through the JAL state; when
//           undefined it is treated as an illegal opcode and code 9 is unused.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous, active-high reset (forces FETCH)
//   op_i[6:0]     opcode from the instruction register
//   zero_i        ALU zero flag (used in BEQ)
//   mem_ready_i   memory handshake; an access completes on an edge with 1
//   pc_write_o    PC load enable (pc_update | branch & zero)
//   adr_src_o     memory address select: 0=PC, 1=ALU-out register
//   mem_write_o   data memory write strobe
//   ir_write_o    instruction register load enable
//   reg_write_o   register file write enable
//   result_src_o  result select: 00=ALU-out reg, 01=read data, 10=ALU result
//   alu_src_a_o   ALU A select: 00=PC, 01=old PC, 10=rs1
//   alu_src_b_o   ALU B select: 00=rs2, 01=immediate, 10=constant 4
//   alu_op_o      ALU decoder class: 00=add, 01=sub, 10=funct-decoded
//   illegal_op_o  pulse while in DECODE with an unsupported opcode
//   state_o[3:0]  current state code, for debug
// -----------------------------------------------------------------------------
module multicycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic       illegal_op_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef JAL_EN
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

  // Registered Moore controls. The *_rdy bits are only enables: the actual
  // strobe is qualified by mem_ready_i at the output.
  typedef struct packed {
    logic       adr_src;
    logic       ir_write_rdy;
    logic       pc_update_rdy;
    logic       pc_update;
    logic       mem_write_rdy;
    logic       branch;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctrl_q;

  // Control word for a given state; unlisted fields stay 0.
  function automatic ctrl_t decode_ctrl(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b     = 2'b10;
        c.result_src    = 2'b10;
        c.ir_write_rdy  = 1'b1;
        c.pc_update_rdy = 1'b1;
      end
      S_DECODE: begin
        // Precompute the branch target (old PC + immediate).
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        c.adr_src = 1'b1;
      end
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src       = 1'b1;
        c.mem_write_rdy = 1'b1;
      end
      S_EXECR: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
      end
      S_BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
`ifdef JAL_EN
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic op_supported(input logic [6:0] op);
    logic ok;
    ok = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
         (op == OP_ITYPE) || (op == OP_BRANCH);
`ifdef JAL_EN
    ok = ok || (op == OP_JAL);
`endif
    return ok;
  endfunction

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no
    // latch is inferred.
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
`ifdef JAL_EN
          OP_JAL:            state_d = S_JAL;
`endif
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = mem_ready_i ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready_i ? S_FETCH : S_MEMWRITE;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
`ifdef JAL_EN
      S_JAL:      state_d = S_ALUWB;
`endif
      // Unused codes (and 9 without JAL_EN) recover to FETCH.
      default:    state_d = S_FETCH;
    endcase
  end

  // State and control word move together, so ctrl_q always equals
  // decode_ctrl(state_q).
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state.
    if (rst) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_ctrl(S_FETCH);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

  logic pc_update;
  assign pc_update    = ctrl_q.pc_update | (ctrl_q.pc_update_rdy & mem_ready_i);
  assign pc_write_o   = pc_update | (ctrl_q.branch & zero_i);
  assign adr_src_o    = ctrl_q.adr_src;
  assign ir_write_o   = ctrl_q.ir_write_rdy & mem_ready_i;
  // Reset is synchronous, so the state may still be a write state during the
  // reset cycle; block the writes directly.
  assign mem_write_o  = ctrl_q.mem_write_rdy & mem_ready_i & ~rst;
  assign reg_write_o  = ctrl_q.reg_write & ~rst;
  assign result_src_o = ctrl_q.result_src;
  assign alu_src_a_o  = ctrl_q.alu_src_a;
  assign alu_src_b_o  = ctrl_q.alu_src_b;
  assign alu_op_o     = ctrl_q.alu_op;
  assign illegal_op_o = (state_q == S_DECODE) & ~op_supported(op_i);
  assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed vector table for the instruction walk-throughs and reset corners,
//   followed by randomized instruction streams with random mem_ready stalls,
//   zero flag and occasional resets, checked against an instruction-level
//   reference model (per-opcode state path plus a per-state output table).
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] ILL = 7'b1111111;
`ifdef JAL_EN
  localparam bit JAL_ON = 1'b1;
`else
  localparam bit JAL_ON = 1'b0;
`endif

  logic       clk, rst;
  logic [6:0] op;
  logic       zero, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .op_i         (op),
    .zero_i       (zero),
    .mem_ready_i  (mem_ready),
    .pc_write_o   (pc_write),
    .adr_src_o    (adr_src),
    .mem_write_o  (mem_write),
    .ir_write_o   (ir_write),
    .reg_write_o  (reg_write),
    .result_src_o (result_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .alu_op_o     (alu_op),
    .illegal_op_o (illegal_op),
    .state_o      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Full output vector, same field order on both sides.
  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] res, a, b, alu;
    logic       ill;
  } out_t;

  out_t act;
  assign act = {state, pc_write, adr_src, mem_write, ir_write, reg_write,
                result_src, alu_src_a, alu_src_b, alu_op, illegal_op};

  // ---------------------------------------------------------------------------
  // Reference model: per-state datapath settings, as tabulated in the design
  // description, plus the rules for the handshake-qualified strobes.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       adr;
    logic [1:0] a, b, alu, res;
    logic       rw, irw_mr, pcu_mr, pcu, mw_mr, br;
  } ref_t;

  ref_t tbl [16];

  function automatic ref_t r(logic adr, logic [1:0] a, logic [1:0] b, logic [1:0] alu,
                             logic [1:0] res, logic rw, logic irw_mr, logic pcu_mr,
                             logic pcu, logic mw_mr, logic br);
    ref_t x;
    x = {adr, a, b, alu, res, rw, irw_mr, pcu_mr, pcu, mw_mr, br};
    return x;
  endfunction

  task automatic init_table();
    for (int i = 0; i < 16; i++) tbl[i] = '0;
    //            adr a      b      alu    res    rw irw pmr pcu mw br
    tbl[0]  = r(0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 1, 1, 0, 0, 0);
    tbl[1]  = r(0, 2'b01, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[2]  = r(0, 2'b10, 2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[3]  = r(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[4]  = r(0, 2'b00, 2'b00, 2'b00, 2'b01, 1, 0, 0, 0, 0, 0);
    tbl[5]  = r(1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
    tbl[6]  = r(0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
    tbl[7]  = r(0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0, 0, 0, 0);
    tbl[8]  = r(0, 2'b10, 2'b01, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0);
    if (JAL_ON)
      tbl[9] = r(0, 2'b01, 2'b10, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0);
    tbl[10] = r(0, 2'b10, 2'b00, 2'b01, 2'b00, 0, 0, 0, 0, 0, 1);
  endtask

  function automatic logic legal(logic [6:0] o);
    return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) ||
           (JAL_ON && o == JL);
  endfunction

  function automatic out_t model(logic [3:0] st, logic [6:0] o, logic mr, logic z, logic rs);
    ref_t  t;
    out_t  e;
    logic  pcu;
    t     = tbl[st];
    pcu   = t.pcu | (t.pcu_mr & mr);
    e.st  = st;
    e.pcw = pcu | (t.br & z);
    e.adr = t.adr;
    e.mw  = t.mw_mr & mr & ~rs;
    e.irw = t.irw_mr & mr;
    e.rw  = t.rw & ~rs;
    e.res = t.res;
    e.a   = t.a;
    e.b   = t.b;
    e.alu = t.alu;
    e.ill = (st == 4'd1) && !legal(o);
    return e;
  endfunction

  // Instruction-level state path (no stalls) for an opcode.
  logic [3:0] path [5];
  int         plen;

  task automatic set_path(input logic [6:0] o);
    path[0] = 4'd0; path[1] = 4'd1; plen = 2;
    if (o == LW)              begin path[2] = 2; path[3] = 3; path[4] = 4; plen = 5; end
    else if (o == SW)         begin path[2] = 2; path[3] = 5; plen = 4; end
    else if (o == RT)         begin path[2] = 6; path[3] = 7; plen = 4; end
    else if (o == IT)         begin path[2] = 8; path[3] = 7; plen = 4; end
    else if (o == BQ)         begin path[2] = 10; plen = 3; end
    else if (JAL_ON && o == JL) begin path[2] = 9; path[3] = 7; plen = 4; end
  endtask

  function automatic logic waits(logic [3:0] st);
    return (st == 4'd0) || (st == 4'd3) || (st == 4'd5);
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vectors: inputs for one cycle and the expected key outputs.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       rst;
    logic [6:0] op;
    logic       zero, mr;
    logic [3:0] st;
    logic       pcw, mw, irw, rw, ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rs, logic [6:0] o, logic z, logic mr, logic [3:0] st,
                              logic pcw, logic mw, logic irw, logic rw, logic ill);
    vec_t v;
    v.rst = rs; v.op = o; v.zero = z; v.mr = mr; v.st = st;
    v.pcw = pcw; v.mw = mw; v.irw = irw; v.rw = rw; v.ill = ill;
    return v;
  endfunction

  task automatic build_vectors();
    // rst st-in-FETCH; FETCH with mr=1 shows pc_write and ir_write
    vecs.push_back(mk(1, LW, 0, 1, 0, 1, 0, 1, 0, 0));
    // lw, mem_ready high: 0,1,2,3,4
    vecs.push_back(mk(0, LW, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, LW, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, LW, 0, 1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, LW, 0, 1, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, LW, 0, 1, 4, 0, 0, 0, 1, 0));
    // sw with two stall cycles in MEMWRITE; single write on the third
    vecs.push_back(mk(0, SW, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, SW, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, SW, 0, 1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, SW, 0, 0, 5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, SW, 0, 0, 5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, SW, 0, 1, 5, 0, 1, 0, 0, 0));
    // beq taken / not taken
    vecs.push_back(mk(0, BQ, 1, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, BQ, 1, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, BQ, 1, 1, 10, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, BQ, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, BQ, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, BQ, 0, 1, 10, 0, 0, 0, 0, 0));
    // illegal opcode
    vecs.push_back(mk(0, ILL, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, ILL, 0, 1, 1, 0, 0, 0, 0, 1));
    // FETCH stall, then reset during a MEMREAD stall
    vecs.push_back(mk(0, LW, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, LW, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, LW, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, LW, 0, 1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, LW, 0, 0, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, LW, 0, 0, 3, 0, 0, 0, 0, 0));
    // R-type after the reset
    vecs.push_back(mk(0, RT, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, RT, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, RT, 0, 1, 6, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, RT, 0, 1, 7, 0, 0, 0, 1, 0));
    // reset in MEMWB suppresses reg_write
    vecs.push_back(mk(0, LW, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, LW, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, LW, 0, 1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, LW, 0, 1, 3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, LW, 0, 1, 4, 0, 0, 0, 0, 0));
    // reset in MEMWRITE with mem_ready high suppresses mem_write
    vecs.push_back(mk(0, SW, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, SW, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, SW, 0, 1, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, SW, 0, 1, 5, 0, 0, 0, 0, 0));
    // I-type
    vecs.push_back(mk(0, IT, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, IT, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, IT, 0, 1, 8, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, IT, 0, 1, 7, 0, 0, 0, 1, 0));
    // jal: legal only with JAL_EN
    vecs.push_back(mk(0, JL, 0, 1, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, JL, 0, 1, 1, 0, 0, 0, 0, !JAL_ON));
    if (JAL_ON) begin
      vecs.push_back(mk(0, JL, 0, 1, 9, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, JL, 0, 1, 7, 0, 0, 0, 1, 0));
    end
    vecs.push_back(mk(0, LW, 0, 1, 0, 1, 0, 1, 0, 0));
  endtask

  task automatic run_vectors();
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; op = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].mr;
      #2;
      check($sformatf("vec%0d st/pcw/mw/irw/rw/ill", i),
            32'({state, pc_write, mem_write, ir_write, reg_write, illegal_op}),
            32'({vecs[i].st, vecs[i].pcw, vecs[i].mw, vecs[i].irw, vecs[i].rw, vecs[i].ill}));
      @(posedge clk); #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Random instruction stream against the reference model.
  // ---------------------------------------------------------------------------
  task automatic run_random();
    logic [6:0] iop;
    int         idx, stalls;
    bit         aborted;
    rst = 1'b1; mem_ready = 1'b1; op = LW;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 7))
        0: iop = LW;
        1: iop = SW;
        2: iop = RT;
        3: iop = IT;
        4: iop = BQ;
        5: iop = JL;
        default: iop = 7'($urandom);
      endcase
      set_path(iop);
      op = iop;
      idx = 0; stalls = 0; aborted = 1'b0;
      while (idx < plen && !aborted) begin
        mem_ready = ($urandom_range(0, 3) != 0) || (stalls >= 4);
        zero      = 1'($urandom_range(0, 1));
        rst       = ($urandom_range(0, 99) == 0);
        #2;
        check("rand outputs", 32'(act), 32'(model(path[idx], op, mem_ready, zero, rst)));
        @(posedge clk); #1;
        if (rst) aborted = 1'b1;
        else if (waits(path[idx]) && !mem_ready) stalls++;
        else begin idx++; stalls = 0; end
      end
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; op = LW; zero = 1'b0; mem_ready = 1'b1;
    init_table();
    build_vectors();
    @(posedge clk); @(posedge clk); #1;
    run_vectors();
    run_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
